seq_mult_nb: RTL and testbench
==============================

# seq_mult_nb

Parametrised sequential shift-and-add multiplier. It takes two n-bit operands and produces a 2n-bit product. Operation is controlled by a start/busy/done handshake, with an optional two's-complement mode and optional early termination when the remaining multiplier bits are zero. It is the reusable arithmetic core behind the board multiplier demos. It is clocked by the divided clock, and its product feeds `univ_sseg` or any downstream register.

## Interface

**Parameters**
- `n`, default 6: operand width in bits. Legal range is 2–16. The product is 2n bits.
- `EARLY`, default 1: 1 enables early termination; 0 always runs exactly n steps.

**Ports**
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `clr` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: request a multiply. Sampled only in IDLE.
- `sgn` input, 1 bit: 1 treats `a` and `b` as two's complement; 0 treats them as unsigned. Sampled with `start`.
- `a` input, n bits: multiplicand. Sampled with `start`.
- `b` input, n bits: multiplier. Sampled with `start`.
- `busy` output, 1 bit: high in RUN and DONE.
- `done` output, 1 bit: one-cycle pulse; `prod` is valid in that cycle.
- `prod` output, 2n bits: registered product. Holds its value until the next completion.

## Operation

**States:** IDLE, RUN, DONE. The encoding is free.

**Reset (`clr`=1, async):**
- state is IDLE.
- `busy`=0, `done`=0, `prod`=0.
- all internal registers are 0.

**IDLE:**
- If `start`=1 at a rising edge, the block loads:
  - `mcand` (2n bits) = |a|, zero-extended
  - `mplier` (n bits) = |b|
  - `acc` (2n bits) = 0
  - `cnt` = 0
  - `neg` = sgn & (a[n-1] ^ b[n-1])
  - next state = RUN
- |x| is the two's-complement magnitude when `sgn`=1 and the operand is negative; otherwise it is x. The magnitude of −2^(n-1) is 2^(n-1), which is representable unsigned in n bits.

**RUN (one step per edge):**
- `acc_next` = acc + (mplier[0] ? mcand : 0), computed in 2n bits. It cannot overflow.
- `mcand` <<= 1, `mplier` >>= 1, `cnt` += 1.
- The block exits to DONE on the step where `cnt`==n-1, or, if `EARLY`=1, where (mplier>>1)==0.
- On the exiting edge, `prod` <= neg ? −acc_next : acc_next, taken mod 2^(2n).

**DONE:**
- `done`=1 for exactly one cycle.
- The next state is IDLE unconditionally.

**Handshake:**
- `start` is ignored while `busy`=1. There is no queuing.
- `a`, `b` and `sgn` may change freely after the sampling edge.

**Back-to-back operation:** a `start` held high through DONE is sampled in the IDLE cycle that follows. The minimum issue interval is therefore r+2 edges.

**Reset mid-operation:** the operation is abandoned and all outputs return to their reset values immediately. A `start` after `clr` deasserts operates normally.

## Timing

- Let E0 be the edge that samples `start` in IDLE.
- Step count r:
  - with `EARLY`=0, r = n.
  - with `EARLY`=1, r = max(1, p+1), where p is the index of the highest set bit of |b|.
- `busy` rises after E0.
- `prod` updates and `done` rises after edge Er.
- `done` falls and `busy` falls after Er+1.
- Outputs are all registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Test plan

All scenarios use n=6.

- **Reset:** assert `clr` asynchronously between edges → `busy`=0, `done`=0, `prod`=0 immediately, with no clock edge needed.
- **Unsigned full-length:** EARLY=0, sgn=0, a=63, b=63, start pulse → `done` after E6, `prod`=3969 (12'hF81), `busy` high for 7 cycles. Repeat with EARLY=1 → same timing, because b[5]=1.
- **Signed versus unsigned, same bits:**
  - sgn=1, a=6'b111011 (−5), b=3 → `prod`=12'hFF1 (−15), done after E2 with EARLY=1.
  - sgn=0 with the same bits → `prod`=177 (12'h0B1).
- **Signed extremes:** sgn=1, a=−32, b=−32 → `prod`=1024 (12'h400). Then a=−32, b=31 → `prod`=12'hC20 (−992).
- **Early termination and zero:** EARLY=1.
  - b=0, a=45 → `done` after E1, `prod`=0.
  - b=1, a=45 → `done` after E1, `prod`=45.
  - b=6'b000100, a=10 → `done` after E3, `prod`=40.
- **Protocol and reset mid-operation:**
  - Pulse `start` with new operands during RUN → ignored; the first result is unchanged.
  - Hold `start` high continuously → a new operation begins the cycle after each `done`.
  - Assert `clr` after E3 → `busy`=0, `prod`=0, and no `done`. The next start, a=7, b=9, gives `prod`=63.

Source files
------------

// File: rtl/seq_mult_nb.sv
// Sequential shift-and-add multiplier: n x n -> 2n, unsigned or two's complement.
// Latency: r steps after the start edge (r = n, or fewer with EARLY), then a one-cycle done.
// Backpressure: none; start is ignored while busy and requests are never queued.
//
// Ports:
//   clk   - rising-edge clock
//   clr   - asynchronous active-high reset
//   start - request a multiply; sampled only in IDLE
//   sgn   - 1 = operands are two's complement; sampled with start
//   a, b  - multiplicand / multiplier (n bits); sampled with start
//   busy  - high in RUN and DONE
//   done  - one-cycle pulse; prod is valid in that cycle
//   prod  - registered 2n-bit product, held until the next completion
module seq_mult_nb #(
  parameter int n     = 6,   // operand width, 2..16
  parameter int EARLY = 1    // 1: stop once the remaining multiplier bits are zero
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic           sgn,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] prod
);

  localparam int W  = 2 * n;
  localparam int CW = $clog2(n);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]  mcand;
  logic [n-1:0]  mplier;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          neg;

  logic [n-1:0]  a_mag;
  logic [n-1:0]  b_mag;
  logic [W-1:0]  acc_sum;
  logic [W-1:0]  prod_val;
  logic          last_step;
  logic          load;
  logic          step;

  // Magnitudes: negating -2^(n-1) wraps back to 2^(n-1), which is the
  // correct unsigned magnitude in n bits, so no extra width is needed.
  always_comb begin
    a_mag = (sgn && a[n-1]) ? (~a + 1'b1) : a;
    b_mag = (sgn && b[n-1]) ? (~b + 1'b1) : b;
  end

  // Datapath arithmetic for the current RUN step. The sum of at most n
  // shifted copies of an n-bit magnitude fits in 2n bits.
  always_comb begin
    acc_sum   = acc + (mplier[0] ? mcand : '0);
    prod_val  = neg ? (~acc_sum + 1'b1) : acc_sum;
    last_step = (cnt == CW'(n - 1));
    if (EARLY != 0 && (mplier >> 1) == '0) begin
      last_step = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand, accumulator and result registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      prod   <= '0;
    end else if (load) begin
      mcand  <= {{n{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= '0;
      neg    <= sgn & (a[n-1] ^ b[n-1]);
    end else if (step) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      // The result register only moves on the exiting step, so it keeps
      // the previous product visible for the whole of the next operation.
      if (last_step) begin
        prod <= prod_val;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_nb.sv
module tb_seq_mult_nb;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [5:0]  a = '0;
  logic [5:0]  b = '0;
  logic        busy_e, done_e, busy_f, done_f;
  logic [11:0] prod_e, prod_f;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_mult_nb #(.n(6), .EARLY(1)) dut_e (
    .clk(clk), .clr(clr), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy_e), .done(done_e), .prod(prod_e)
  );

  seq_mult_nb #(.n(6), .EARLY(0)) dut_f (
    .clk(clk), .clr(clr), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy_f), .done(done_f), .prod(prod_f)
  );

  // Reference: number of steps from the value of the multiplier.
  function automatic int model_r(bit early, bit s, logic [5:0] bv);
    int m;
    if (!early) return 6;
    m = (s && bv[5]) ? 64 - int'(bv) : int'(bv);
    for (int i = 5; i >= 0; i--) begin
      if (m >= (1 << i)) return i + 1;
    end
    return 1;
  endfunction

  // Reference: plain integer product truncated to 12 bits.
  function automatic logic [11:0] model_prod(bit s, logic [5:0] av, logic [5:0] bv);
    int x, y;
    x = (s && av[5]) ? int'(av) - 64 : int'(av);
    y = (s && bv[5]) ? int'(bv) - 64 : int'(bv);
    return 12'(x * y);
  endfunction

  // Launches one operation and records what both instances did over a
  // bounded window of 12 edges after the sampling edge.
  task automatic do_op(input bit s, input logic [5:0] av, input logic [5:0] bv,
                       input bit poke,
                       output int dk_e, output int dk_f,
                       output int nd_e, output int nd_f,
                       output int bz_e, output int bz_f,
                       output logic [11:0] p_e, output logic [11:0] p_f,
                       output bit hold_e, output bit hold_f);
    logic [11:0] old_e, old_f;
    dk_e = -1; dk_f = -1; nd_e = 0; nd_f = 0; bz_e = 0; bz_f = 0;
    p_e = 'x; p_f = 'x; hold_e = 1'b1; hold_f = 1'b1;
    @(negedge clk);
    old_e = prod_e; old_f = prod_f;
    sgn = s; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    bz_e += int'(busy_e); bz_f += int'(busy_f);
    start = 1'b0; a = 6'($urandom); b = 6'($urandom); sgn = 1'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      bz_e += int'(busy_e); bz_f += int'(busy_f);
      if (done_e) begin
        nd_e++;
        if (dk_e < 0) begin dk_e = k; p_e = prod_e; end
      end else if (dk_e < 0 && prod_e !== old_e) hold_e = 1'b0;
      if (done_f) begin
        nd_f++;
        if (dk_f < 0) begin dk_f = k; p_f = prod_f; end
      end else if (dk_f < 0 && prod_f !== old_f) hold_f = 1'b0;
      if (poke) begin
        start = (k == 2);
        a = 6'($urandom); b = 6'($urandom); sgn = 1'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if (busy_e !== 1'b0 || done_e !== 1'b0 || prod_e !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_e: busy=%b done=%b prod=%h required 0 0 000", busy_e, done_e, prod_e);
    end
    vectors++;
    if (busy_f !== 1'b0 || done_f !== 1'b0 || prod_f !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_f: busy=%b done=%b prod=%h required 0 0 000", busy_f, done_f, prod_f);
    end
    @(negedge clk); clr = 1'b0;
  endtask

  // Runs one operation and checks both instances against the reference.
  task automatic test_op(input string name, input bit s, input logic [5:0] av,
                         input logic [5:0] bv, input bit poke);
    int dk_e, dk_f, nd_e, nd_f, bz_e, bz_f, re;
    logic [11:0] p_e, p_f, ex;
    bit h_e, h_f;
    do_op(s, av, bv, poke, dk_e, dk_f, nd_e, nd_f, bz_e, bz_f, p_e, p_f, h_e, h_f);
    ex = model_prod(s, av, bv);
    re = model_r(1'b1, s, bv);
    vectors++;
    if (p_e !== ex) begin miscompares++; $display("FAIL %s prod_e: got %h required %h", name, p_e, ex); end
    vectors++;
    if (p_f !== ex) begin miscompares++; $display("FAIL %s prod_f: got %h required %h", name, p_f, ex); end
    vectors++;
    if (dk_e !== re) begin miscompares++; $display("FAIL %s done_edge_e: got %0d required %0d", name, dk_e, re); end
    vectors++;
    if (dk_f !== 6) begin miscompares++; $display("FAIL %s done_edge_f: got %0d required 6", name, dk_f); end
    vectors++;
    if (bz_e !== re + 1 || bz_f !== 7) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d/%0d required %0d/7", name, bz_e, bz_f, re + 1);
    end
    vectors++;
    if (nd_e !== 1 || nd_f !== 1) begin
      miscompares++;
      $display("FAIL %s done_count: got %0d/%0d required 1/1", name, nd_e, nd_f);
    end
    vectors++;
    if (!h_e || !h_f) begin
      miscompares++;
      $display("FAIL %s prod_hold: got %0b/%0b required 1/1", name, h_e, h_f);
    end
  endtask

  task automatic test_unsigned_full;
    test_op("unsigned_63x63", 1'b0, 6'd63, 6'd63, 1'b0);
    vectors++;
    if (prod_e !== 12'hF81) begin miscompares++; $display("FAIL full_const: got %h required f81", prod_e); end
  endtask

  task automatic test_signed;
    test_op("signed_m5x3", 1'b1, 6'b111011, 6'd3, 1'b0);
    vectors++;
    if (prod_e !== 12'hFF1) begin miscompares++; $display("FAIL signed_const: got %h required ff1", prod_e); end
    test_op("unsigned_59x3", 1'b0, 6'b111011, 6'd3, 1'b0);
    vectors++;
    if (prod_e !== 12'h0B1) begin miscompares++; $display("FAIL unsigned_const: got %h required 0b1", prod_e); end
    test_op("signed_m32xm32", 1'b1, 6'b100000, 6'b100000, 1'b0);
    vectors++;
    if (prod_e !== 12'h400) begin miscompares++; $display("FAIL ext1_const: got %h required 400", prod_e); end
    test_op("signed_m32x31", 1'b1, 6'b100000, 6'd31, 1'b0);
    vectors++;
    if (prod_f !== 12'hC20) begin miscompares++; $display("FAIL ext2_const: got %h required c20", prod_f); end
  endtask

  task automatic test_early;
    test_op("early_b0", 1'b0, 6'd45, 6'd0, 1'b0);
    test_op("early_b1", 1'b0, 6'd45, 6'd1, 1'b0);
    vectors++;
    if (prod_e !== 12'd45) begin miscompares++; $display("FAIL early_b1_const: got %0d required 45", prod_e); end
    test_op("early_b4", 1'b0, 6'd10, 6'd4, 1'b0);
    vectors++;
    if (prod_e !== 12'd40) begin miscompares++; $display("FAIL early_b4_const: got %0d required 40", prod_e); end
  endtask

  task automatic test_ignore_start;
    // A start pulse with fresh operands lands while both instances are in RUN.
    test_op("ignore_start", 1'b0, 6'd63, 6'd63, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      test_op("random", 1'($urandom), 6'($urandom), 6'($urandom), 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    int de[$];
    int df[$];
    int bound;
    logic [11:0] ex;
    ex = model_prod(1'b0, 6'd11, 6'd5);
    @(negedge clk);
    sgn = 1'b0; a = 6'd11; b = 6'd5; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (done_e) begin
        de.push_back(k);
        vectors++;
        if (prod_e !== ex) begin miscompares++; $display("FAIL b2b_prod_e: got %h required %h", prod_e, ex); end
      end
      if (done_f) begin
        df.push_back(k);
        vectors++;
        if (prod_f !== ex) begin miscompares++; $display("FAIL b2b_prod_f: got %h required %h", prod_f, ex); end
      end
    end
    start = 1'b0;
    // Issue interval is r+2: EARLY instance r=3, full-length instance r=6.
    vectors++;
    if (de.size() !== 5 || de[0] !== 3 || de[1] - de[0] !== 5 || de[4] !== 23) begin
      miscompares++;
      $display("FAIL b2b_timing_e: got count=%0d first=%0d required count=5 first=3 gap=5", de.size(), (de.size() > 0) ? de[0] : -1);
    end
    vectors++;
    if (df.size() !== 3 || df[0] !== 6 || df[1] - df[0] !== 8 || df[2] !== 22) begin
      miscompares++;
      $display("FAIL b2b_timing_f: got count=%0d first=%0d required count=3 first=6 gap=8", df.size(), (df.size() > 0) ? df[0] : -1);
    end
    bound = 0;
    while ((busy_e || busy_f) && bound < 20) begin
      @(posedge clk); #1;
      bound++;
    end
    vectors++;
    if (busy_e !== 1'b0 || busy_f !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: busy=%b/%b required 0/0", busy_e, busy_f);
    end
  endtask

  task automatic test_reset_mid;
    int dk_e, dk_f, nd_e, nd_f, bz_e, bz_f, saw_done;
    logic [11:0] p_e, p_f;
    bit h_e, h_f;
    @(negedge clk);
    sgn = 1'b0; a = 6'd63; b = 6'd63; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin @(posedge clk); #1; end
    #2; clr = 1'b1; #1;
    vectors++;
    if (busy_e !== 1'b0 || done_e !== 1'b0 || prod_e !== 12'h000 ||
        busy_f !== 1'b0 || done_f !== 1'b0 || prod_f !== 12'h000) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b/%b done=%b/%b prod=%h/%h required all zero",
               busy_e, busy_f, done_e, done_f, prod_e, prod_f);
    end
    saw_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done_e || done_f || busy_e || busy_f) saw_done++;
    end
    @(negedge clk); clr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done_e || done_f || busy_e || busy_f) saw_done++;
    end
    vectors++;
    if (saw_done !== 0) begin miscompares++; $display("FAIL mid_reset_quiet: got %0d active cycles required 0", saw_done); end
    do_op(1'b0, 6'd7, 6'd9, 1'b0, dk_e, dk_f, nd_e, nd_f, bz_e, bz_f, p_e, p_f, h_e, h_f);
    vectors++;
    if (p_e !== 12'd63 || p_f !== 12'd63) begin
      miscompares++;
      $display("FAIL after_reset_prod: got %0d/%0d required 63/63", p_e, p_f);
    end
    vectors++;
    if (dk_e !== 4 || dk_f !== 6) begin
      miscompares++;
      $display("FAIL after_reset_timing: got %0d/%0d required 4/6", dk_e, dk_f);
    end
  endtask

  task automatic test_async_reset;
    // Reset lands between edges after a non-zero result has been produced.
    test_op("pre_async", 1'b0, 6'd45, 6'd3, 1'b0);
    @(negedge clk); #1;
    clr = 1'b1; #1;
    vectors++;
    if (busy_e !== 1'b0 || done_e !== 1'b0 || prod_e !== 12'h000 || prod_f !== 12'h000) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b done=%b prod=%h/%h required 0 0 000/000", busy_e, done_e, prod_e, prod_f);
    end
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned_full();
    test_signed();
    test_early();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
